// File: rtl/tournament_predictor.sv
// Tournament branch predictor: gshare + two-level local predictor, PC-indexed chooser,
// direct-mapped BTB. Registered 1-cycle lookup, MEM-stage training, speculative GHR repair.
module tournament_predictor #(
  parameter int GHR_BITS = 8,
  parameter int LHT_BITS = 6,
  parameter int LHR_BITS = 8,
  parameter int BTB_BITS = 6,
  parameter int CTR_BITS = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FLUSH,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  input  logic                lookup_is_branch,
  input  logic                lookup_is_jump,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_is_branch,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredict,
  input  logic [GHR_BITS+1:0] upd_info,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS+1:0] pred_info
);

  localparam int GSIZE  = 1 << GHR_BITS;
  localparam int LSIZE  = 1 << LHT_BITS;
  localparam int LPSIZE = 1 << LHR_BITS;
  localparam int BSIZE  = 1 << BTB_BITS;
  localparam int TAG_W  = 32 - (BTB_BITS + 2);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0] gpht_q [GSIZE];
  logic [CTR_BITS-1:0] cho_q  [GSIZE];
  logic [CTR_BITS-1:0] lpht_q [LPSIZE];
  logic [LHR_BITS-1:0] lht_q  [LSIZE];
  logic                btb_v_q   [BSIZE];
  logic [TAG_W-1:0]    btb_tag_q [BSIZE];
  logic [31:0]         btb_tgt_q [BSIZE];

  logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [GHR_BITS-1:0] commit_ghr_q, commit_ghr_d;

  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic [31:0]         pred_target_q, pred_target_d;
  logic [GHR_BITS+1:0] pred_info_q, pred_info_d;

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                   input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // Lookup path: reads pre-update table contents.
  logic [GHR_BITS-1:0] l_gidx, l_cidx;
  logic [LHT_BITS-1:0] l_lidx;
  logic [LHR_BITS-1:0] l_lhist;
  logic [BTB_BITS-1:0] l_bidx;
  logic [TAG_W-1:0]    l_tag;
  logic l_gpred, l_lpred, l_sel, l_hit, l_dir;

  assign l_gidx  = lookup_pc[GHR_BITS+1:2] ^ spec_ghr_q;
  assign l_cidx  = lookup_pc[GHR_BITS+1:2];
  assign l_lidx  = lookup_pc[LHT_BITS+1:2];
  assign l_lhist = lht_q[l_lidx];
  assign l_bidx  = lookup_pc[BTB_BITS+1:2];
  assign l_tag   = lookup_pc[31:BTB_BITS+2];
  assign l_gpred = gpht_q[l_gidx][CTR_BITS-1];
  assign l_lpred = lpht_q[l_lhist][CTR_BITS-1];
  assign l_sel   = cho_q[l_cidx][CTR_BITS-1] ? l_gpred : l_lpred;
  assign l_hit   = btb_v_q[l_bidx] && (btb_tag_q[l_bidx] == l_tag);
  assign l_dir   = lookup_is_branch ? l_sel : lookup_is_jump;

  // Update path.
  logic                u_train, u_btb_wr;
  logic [GHR_BITS-1:0] u_gidx, u_cidx;
  logic [LHT_BITS-1:0] u_lidx;
  logic [LHR_BITS-1:0] u_lhist;
  logic [BTB_BITS-1:0] u_bidx;

  assign u_train  = upd_valid && upd_is_branch;
  assign u_btb_wr = upd_valid && upd_taken && (upd_is_branch || upd_is_jump);
  assign u_gidx   = upd_pc[GHR_BITS+1:2] ^ upd_info[GHR_BITS+1:2];
  assign u_cidx   = upd_pc[GHR_BITS+1:2];
  assign u_lidx   = upd_pc[LHT_BITS+1:2];
  assign u_lhist  = lht_q[u_lidx];
  assign u_bidx   = upd_pc[BTB_BITS+1:2];

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    commit_ghr_d = commit_ghr_q;
    if (u_train) commit_ghr_d = {commit_ghr_q[GHR_BITS-2:0], upd_taken};
    // Repair and flush both restore from the committed history including this update.
    spec_ghr_d = spec_ghr_q;
    if ((upd_valid && upd_mispredict) || FLUSH)
      spec_ghr_d = commit_ghr_d;
    else if (lookup_valid && lookup_is_branch)
      spec_ghr_d = {spec_ghr_q[GHR_BITS-2:0], l_sel};
  end

  // pred_valid is a one-cycle strobe; the other outputs are zero whenever it is low.
  always_comb begin
    pred_valid_d  = 1'b0;
    pred_taken_d  = 1'b0;
    pred_target_d = '0;
    pred_info_d   = '0;
    if (lookup_valid && !FLUSH) begin
      pred_valid_d  = 1'b1;
      pred_taken_d  = l_dir && l_hit;
      pred_target_d = l_hit ? btb_tgt_q[l_bidx] : '0;
      pred_info_d   = {spec_ghr_q, l_gpred, l_lpred};
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      spec_ghr_q    <= '0;
      commit_ghr_q  <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_info_q   <= '0;
    end else begin
      spec_ghr_q    <= spec_ghr_d;
      commit_ghr_q  <= commit_ghr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_info_q   <= pred_info_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < GSIZE; i++) begin
        gpht_q[i] <= CTR_INIT;
        cho_q[i]  <= CTR_INIT;
      end
      for (int i = 0; i < LPSIZE; i++) lpht_q[i] <= CTR_INIT;
      for (int i = 0; i < LSIZE; i++) lht_q[i] <= '0;
      for (int i = 0; i < BSIZE; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else begin
      if (u_train) begin
        gpht_q[u_gidx]  <= sat_step(gpht_q[u_gidx], upd_taken);
        lpht_q[u_lhist] <= sat_step(lpht_q[u_lhist], upd_taken);
        lht_q[u_lidx]   <= {u_lhist[LHR_BITS-2:0], upd_taken};
        // Chooser only learns when the two component predictions disagreed.
        if (upd_info[1] != upd_info[0])
          cho_q[u_cidx] <= sat_step(cho_q[u_cidx], upd_info[1] == upd_taken);
      end
      if (u_btb_wr) begin
        btb_v_q[u_bidx]   <= 1'b1;
        btb_tag_q[u_bidx] <= upd_pc[31:BTB_BITS+2];
        btb_tgt_q[u_bidx] <= upd_target;
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_info   = pred_info_q;

endmodule
